// File: rtl/dna_reader.sv
// Bus initiator that reads a block of 16-bit DNA words from the shared RAM port
// through the latch/ready handshake and streams them out through a small FIFO.
module dna_reader #(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 16,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  input  logic              ramReady,
  input  logic [DATA_W-1:0] ramBusDataOut,
  output logic [ADDR_W-1:0] ramBusAddr,
  output logic              ramLatch,
  output logic              ramInstruction
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_count;
  logic [LEN_W-1:0]  r_issued;
  logic [LEN_W-1:0]  r_received;
  logic [TO_W-1:0]   r_wcnt;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic              r_latch;
  logic [ADDR_W-1:0] r_addr;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_fcnt;

  logic              w_pop;
  logic              w_push;
  logic              w_free;
  logic              w_issue;
  logic              w_timeout;
  logic [ADDR_W-1:0] w_issue_addr;
  logic [LEN_W-1:0]  w_recv_next;

  assign rd_valid       = (r_fcnt != '0);
  assign rd_data        = rd_valid ? r_mem[r_rptr] : '0;
  assign busy           = r_busy;
  assign done           = r_done;
  assign error          = r_error;
  assign ramLatch       = r_latch;
  assign ramBusAddr     = r_addr;
  assign ramInstruction = 1'b0;

  assign w_pop        = rd_valid & rd_ready;
  // The first WAIT cycle still sees ramReady from before the controller took the strobe.
  assign w_push       = (r_state == S_WAIT) && (r_wcnt != '0) && ramReady;
  assign w_free       = (r_fcnt != CNT_W'(FIFO_DEPTH));
  assign w_issue      = (r_state == S_ISSUE) && ramReady && w_free;
  assign w_timeout    = (r_state == S_WAIT) && !w_push && (r_wcnt == TO_W'(TIMEOUT - 1));
  assign w_issue_addr = r_base + ADDR_W'(r_issued);
  assign w_recv_next  = r_received + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= ramBusDataOut;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else if (w_timeout) begin
      r_rptr <= r_wptr;
      r_fcnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + CNT_W'(1);
        2'b01:   r_fcnt <= r_fcnt - CNT_W'(1);
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_count    <= '0;
      r_issued   <= '0;
      r_received <= '0;
      r_wcnt     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_latch    <= 1'b0;
      r_addr     <= '0;
    end else begin
      r_done  <= 1'b0;
      r_latch <= 1'b0;
      r_addr  <= '0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base     <= base_addr;
            r_count    <= word_count;
            r_issued   <= '0;
            r_received <= '0;
            r_error    <= 1'b0;
            if (word_count == '0) begin
              r_done <= 1'b1;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (w_issue) begin
            r_latch  <= 1'b1;
            r_addr   <= w_issue_addr;
            r_issued <= r_issued + LEN_W'(1);
            r_wcnt   <= '0;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_push) begin
            r_received <= w_recv_next;
            r_state    <= (w_recv_next == r_count) ? S_DRAIN : S_ISSUE;
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_wcnt <= r_wcnt + TO_W'(1);
          end
        end
        S_DRAIN: begin
          if (r_fcnt == '0) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dna_reader.sv
// Bench for dna_reader: RAM controller responder, address/data scoreboards fed
// from a transfer-level reference model, and directed plus random transfers.
module tb_dna_reader;
  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 16;
  localparam int LEN_W   = 16;
  localparam int TIMEOUT = 1023;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  word_count = '0;
  logic              busy, done, error, rd_valid, ramLatch, ramInstruction;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ready = 1'b1;
  logic              ramReady = 1'b1;
  logic [DATA_W-1:0] ramBusDataOut = '0;
  logic [ADDR_W-1:0] ramBusAddr;

  dna_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
               .FIFO_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done), .error(error),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .ramReady(ramReady), .ramBusDataOut(ramBusDataOut),
    .ramBusAddr(ramBusAddr), .ramLatch(ramLatch), .ramInstruction(ramInstruction)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int latch_cnt = 0;
  int done_cnt = 0;
  int done_base = 0;
  int done_cyc = 0;
  int lat_cyc = 0;
  int ctl_n = 0;
  int hang_at = 0;
  int lat_fix = 0;
  bit hang_release = 1'b0;
  logic [15:0] key = 16'h0;
  logic [DATA_W-1:0] exp_data[$];
  logic [ADDR_W-1:0] exp_addr[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
    return key + a[15:0];
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RAM controller: drops ramReady on the edge that takes the strobe, answers later.
  initial begin
    int l;
    logic [ADDR_W-1:0] a;
    forever begin
      @(negedge clk);
      if (ramLatch && !rst) begin
        ctl_n++;
        a = ramBusAddr;
        l = (lat_fix != 0) ? lat_fix : int'($urandom_range(2, 5));
        if (hang_at != 0 && ctl_n == hang_at) lat_cyc = cyc;
        @(posedge clk);
        #1 ramReady = 1'b0;
        if (hang_at != 0 && ctl_n == hang_at) begin
          while (!hang_release) @(posedge clk);
          #1 ramReady = 1'b1;
        end else begin
          repeat (l - 1) @(posedge clk);
          #1;
          ramBusDataOut = ram_word(a);
          ramReady = 1'b1;
        end
      end
    end
  end

  // Monitor: bus strobes, stream output and done pulses.
  initial begin
    bit prev_latch;
    bit prev_hold;
    logic [DATA_W-1:0] prev_data;
    prev_latch = 1'b0;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ramLatch) begin
          latch_cnt++;
          if (exp_addr.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL latch_unexpected actual=0x%0h required=none", ramBusAddr);
          end else begin
            chk("latch_addr", ramBusAddr, exp_addr.pop_front());
          end
          chk("latch_one_cycle", prev_latch, 0);
        end else begin
          chk("addr_idle_zero", ramBusAddr, 0);
        end
        chk("instr_read", ramInstruction, 0);
        prev_latch = ramLatch;
        if (prev_hold) begin
          chk("hold_valid", rd_valid, 1);
          chk("hold_data", rd_data, prev_data);
        end
        if (rd_valid && rd_ready) begin
          if (exp_data.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL word_unexpected actual=0x%0h required=none", rd_data);
          end else begin
            chk("rd_data", rd_data, exp_data.pop_front());
          end
        end
        prev_hold = rd_valid && !rd_ready;
        prev_data = rd_data;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end else begin
        prev_latch = 1'b0;
        prev_hold = 1'b0;
      end
    end
  end

  // Reference model: word i lives at (base+i) mod 2^ADDR_W; a hung read stops delivery.
  task automatic xfer_start(input logic [ADDR_W-1:0] b, input int n);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = b + ADDR_W'(i);
      if (hang_at == 0 || i < hang_at) exp_addr.push_back(a);
      if (hang_at == 0 || i < hang_at - 1) exp_data.push_back(ram_word(a));
    end
    ctl_n = 0;
    latch_cnt = 0;
    done_base = done_cnt;
    @(posedge clk);
    #2;
    start = 1'b1;
    base_addr = b;
    word_count = LEN_W'(n);
    @(posedge clk);
    #2;
    start = 1'b0;
    base_addr = ADDR_W'($urandom);
    word_count = LEN_W'($urandom);
  endtask

  task automatic wait_done(input int budget, input bit rnd, input string name);
    int n;
    n = 0;
    while (done_cnt == done_base && n < budget) begin
      @(posedge clk);
      #2;
      if (rnd) rd_ready = 1'($urandom_range(0, 1));
      n++;
    end
    chk({name, "_done_seen"}, done_cnt, done_base + 1);
    rd_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk({name, "_single_done"}, done_cnt, done_base + 1);
    chk({name, "_busy_low"}, busy, 0);
    chk({name, "_words_left"}, exp_data.size(), 0);
    chk({name, "_addrs_left"}, exp_addr.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] b;
    int n;
    int cnt;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_latch", ramLatch, 0);
    chk("rst_addr", ramBusAddr, 0);
    chk("rst_instr", ramInstruction, 0);
    rst = 1'b0;

    // Basic 3-word read, fixed latency
    key = 16'h0090;
    lat_fix = 3;
    xfer_start(23'h000010, 3);
    wait_done(200, 1'b0, "t1");
    chk("t1_latches", latch_cnt, 3);
    chk("t1_error", error, 0);
    lat_fix = 0;

    // Zero-length transfer
    xfer_start(23'h000055, 0);
    @(negedge clk);
    chk("t2_done_next", done, 1);
    repeat (5) begin
      @(negedge clk);
      chk("t2_busy", busy, 0);
    end
    chk("t2_latches", latch_cnt, 0);
    chk("t2_single_done", done_cnt, done_base + 1);

    // Backpressure: FIFO fills, issue stalls
    key = 16'($urandom);
    b = ADDR_W'($urandom);
    @(posedge clk);
    #2 rd_ready = 1'b0;
    xfer_start(b, 8);
    repeat (40) @(posedge clk);
    #2;
    chk("t3_latches_stalled", latch_cnt, 4);
    chk("t3_valid", rd_valid, 1);
    chk("t3_head", rd_data, key + b[15:0]);
    rd_ready = 1'b1;
    wait_done(400, 1'b0, "t3");
    chk("t3_latches", latch_cnt, 8);

    // Address wrap
    key = 16'($urandom);
    xfer_start(23'h7FFFFE, 4);
    wait_done(200, 1'b0, "t4");
    chk("t4_latches", latch_cnt, 4);

    // Timeout after 2nd latch
    key = 16'($urandom);
    hang_at = 2;
    xfer_start(ADDR_W'($urandom), 5);
    wait_done(TIMEOUT + 300, 1'b0, "t5");
    chk("t5_timeout_cycle", done_cyc - lat_cyc, TIMEOUT);
    chk("t5_error", error, 1);
    chk("t5_fifo_empty", rd_valid, 0);
    chk("t5_latches", latch_cnt, 2);
    hang_release = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    hang_release = 1'b0;
    hang_at = 0;
    chk("t5_error_sticky", error, 1);
    xfer_start(ADDR_W'($urandom), 2);
    @(negedge clk);
    chk("t5_error_cleared", error, 0);
    wait_done(200, 1'b0, "t5b");

    // Reset while waiting on the controller
    key = 16'($urandom);
    hang_at = 1;
    xfer_start(ADDR_W'($urandom), 6);
    n = 0;
    while (ctl_n < 1 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("t6_latched", ctl_n, 1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_error", error, 0);
    chk("t6_rst_valid", rd_valid, 0);
    chk("t6_rst_latch", ramLatch, 0);
    chk("t6_rst_addr", ramBusAddr, 0);
    exp_data.delete();
    exp_addr.delete();
    hang_release = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    hang_release = 1'b0;
    hang_at = 0;
    rst = 1'b0;
    xfer_start(ADDR_W'($urandom), 3);
    wait_done(200, 1'b0, "t6");
    chk("t6_latches", latch_cnt, 3);

    // Random transfers with random consumer stalls and ignored restarts
    for (int k = 0; k < 6; k++) begin
      key = 16'($urandom);
      b = ADDR_W'($urandom);
      cnt = int'($urandom_range(1, 12));
      xfer_start(b, cnt);
      @(posedge clk);
      #2;
      chk("rnd_busy", busy, 1);
      start = 1'b1;
      base_addr = ADDR_W'($urandom);
      word_count = LEN_W'($urandom_range(1, 20));
      @(posedge clk);
      #2 start = 1'b0;
      wait_done(1500, 1'b1, "rnd");
      chk("rnd_latches", latch_cnt, cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
